tlul_adapter_reg_pipe: RTL

Pipelined TL-UL to register-interface adapter, the multi-outstanding successor of the single-outstanding register adapter. It accepts up to `Outstanding` requests back-to-back and drives a single register port with `re_o`/`we_o` strobes. It samples read data after a fixed `AccessLatency` and returns responses in order through an internal response FIFO, so the D channel can stall without dropping data. It sits between a TL-UL crossbar port and a peripheral register file.

---
 rtl/tlul_adapter_reg_pipe.sv | 131 +++++++++++++
 1 files changed

// File: rtl/tlul_adapter_reg_pipe.sv
// tlul_adapter_reg_pipe: pipelined TL-UL to register-port adapter with up to Outstanding
// requests in flight and an in-order response FIFO so the D channel may stall.
module tlul_adapter_reg_pipe #(
    parameter int RegAw         = 8,
    parameter int RegDw         = 32,
    parameter int AccessLatency = 0,
    parameter int Outstanding   = 2,
    parameter int SrcW          = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               a_valid_i,
    output logic               a_ready_o,
    input  logic [2:0]         a_opcode_i,
    input  logic [1:0]         a_size_i,
    input  logic [SrcW-1:0]    a_source_i,
    input  logic [31:0]        a_address_i,
    input  logic [3:0]         a_mask_i,
    input  logic [31:0]        a_data_i,
    output logic               d_valid_o,
    input  logic               d_ready_i,
    output logic [2:0]         d_opcode_o,
    output logic [1:0]         d_size_o,
    output logic [SrcW-1:0]    d_source_o,
    output logic [RegDw-1:0]   d_data_o,
    output logic               d_error_o,
    output logic               re_o,
    output logic               we_o,
    output logic [RegAw-1:0]   addr_o,
    output logic [RegDw-1:0]   wdata_o,
    output logic [RegDw/8-1:0] be_o,
    input  logic               busy_i,
    input  logic [RegDw-1:0]   rdata_i,
    input  logic               error_i
);
    localparam int CW = $clog2(Outstanding + 1);
    localparam int PW = Outstanding > 1 ? $clog2(Outstanding) : 1;

    typedef struct packed {
        logic            vld;
        logic [SrcW-1:0] src;
        logic [1:0]      size;
        logic            rd;
        logic            err;
    } tag_t;

    typedef struct packed {
        logic [SrcW-1:0]  src;
        logic [1:0]       size;
        logic             rd;
        logic             err;
        logic [RegDw-1:0] data;
    } rsp_t;

    logic [CW-1:0] cnt, fcnt;
    logic [PW-1:0] wptr, rptr;
    rsp_t          mem [Outstanding];
    rsp_t          rsp_in, head;
    tag_t          tag_in, tag_out;
    logic          accept, push, pop, rd, wr, req_err, push_err;
    logic [3:0]    full_mask;
    logic          unused_addr;

    assign unused_addr = ^a_address_i[31:RegAw];

    assign rd        = a_opcode_i == 3'd4;
    assign wr        = a_opcode_i == 3'd0 || a_opcode_i == 3'd1;
    assign full_mask = a_size_i == 2'd0 ? 4'h1 : a_size_i == 2'd1 ? 4'h3 : 4'hf;
    assign req_err   = ~(rd | wr) | (|a_address_i[1:0]) | (a_size_i == 2'd3)
                     | (a_opcode_i == 3'd0 && a_mask_i != full_mask);

    assign a_ready_o = rst_ni & ~busy_i & (cnt < CW'(Outstanding));
    assign accept    = a_valid_i & a_ready_o;
    assign we_o      = accept & wr & ~req_err;
    assign re_o      = accept & rd & ~req_err;
    assign addr_o    = {a_address_i[RegAw-1:2], 2'b00};
    assign wdata_o   = a_data_i;
    assign be_o      = a_mask_i;
    assign tag_in    = '{vld: accept, src: a_source_i, size: a_size_i, rd: rd, err: req_err};

    generate
        if (AccessLatency == 0) begin : g_nopipe
            assign tag_out = tag_in;
        end else begin : g_pipe
            tag_t pipe [AccessLatency];
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    for (int i = 0; i < AccessLatency; i++) pipe[i].vld <= 1'b0;
                end else begin
                    pipe[0] <= tag_in;
                    for (int i = 1; i < AccessLatency; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign tag_out = pipe[AccessLatency-1];
        end
    endgenerate

    // error_i only matters when a strobe was issued, i.e. when the tag carries no request error
    assign push     = tag_out.vld;
    assign push_err = tag_out.err | error_i;
    assign rsp_in   = '{src: tag_out.src, size: tag_out.size, rd: tag_out.rd, err: push_err,
                        data: (push_err | ~tag_out.rd) ? {RegDw{1'b1}} : rdata_i};

    assign d_valid_o = rst_ni & (fcnt != '0);
    assign pop       = d_valid_o & d_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt  <= '0;
            fcnt <= '0;
            wptr <= '0;
            rptr <= '0;
        end else begin
            cnt  <= cnt + CW'(accept) - CW'(pop);
            fcnt <= fcnt + CW'(push) - CW'(pop);
            if (push) wptr <= wptr == PW'(Outstanding - 1) ? '0 : wptr + 1'b1;
            if (pop) rptr <= rptr == PW'(Outstanding - 1) ? '0 : rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) if (push) mem[wptr] <= rsp_in;

    always_ff @(posedge clk_i) if (rst_ni) assert (!(push && fcnt == CW'(Outstanding) && !pop));

    assign head       = d_valid_o ? mem[rptr] : '0;
    assign d_opcode_o = {2'b00, head.rd};
    assign d_size_o   = head.size;
    assign d_source_o = head.src;
    assign d_data_o   = head.data;
    assign d_error_o  = head.err;
endmodule
